// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage. It owns the program counter, issues one request at
// a time to instruction memory over a req/ack handshake, and presents the
// fetched PC/instruction pair to the IF/ID register bank. It absorbs:
//   - memory latency (the request is held until acknowledged),
//   - downstream stalls (one-entry skid buffer catches an ack that arrives
//     while IF/ID is full),
//   - branch/jump redirects (the IF/ID slot and skid are flushed, and a
//     request already on the bus is completed and its data thrown away).
//
// Ports:
//   Clk_i          clock, all state changes on the rising edge
//   Clr_i          synchronous active-high reset, overrides everything
//   Stall_i        downstream hold of the IF/ID slot
//   Redirect_i     one-cycle pulse, branch/jump taken
//   RedirectPC_i   redirect target, low two bits ignored
//   ImemReq_o      fetch request valid (registered-state decode only)
//   ImemAddr_o     fetch address, stable while a request is pending
//   ImemAck_i      memory completes the pending request this cycle
//   ImemRdata_i    instruction word returned with the ack
//   IfPC_o         PC of the instruction presented to IF/ID
//   IfInst_o       instruction presented to IF/ID
//   IfValid_o      IfPC_o/IfInst_o hold a live instruction
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            Clk_i,
    input  logic            Clr_i,
    input  logic            Stall_i,
    input  logic            Redirect_i,
    input  logic [XLEN-1:0] RedirectPC_i,
    output logic            ImemReq_o,
    output logic [XLEN-1:0] ImemAddr_o,
    input  logic            ImemAck_i,
    input  logic [XLEN-1:0] ImemRdata_i,
    output logic [XLEN-1:0] IfPC_o,
    output logic [XLEN-1:0] IfInst_o,
    output logic            IfValid_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_SLOT,
        DRAIN
    } state_e;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] ifPc_q, ifPc_d;
    logic [XLEN-1:0] ifInst_q, ifInst_d;
    logic            ifValid_q, ifValid_d;
    logic [XLEN-1:0] skidPc_q, skidPc_d;
    logic [XLEN-1:0] skidInst_q, skidInst_d;

    logic            canAccept;
    logic [XLEN-1:0] redirectTarget;
    logic            unusedRedirectLsbs;

    // Word-aligned redirect target; the low bits are simply dropped.
    assign redirectTarget     = {RedirectPC_i[XLEN-1:2], 2'b00};
    assign unusedRedirectLsbs = ^RedirectPC_i[1:0];

    // The IF/ID slot can take a new entry when it is empty or being consumed.
    assign canAccept = !ifValid_q || !Stall_i;

    // State register. The skid buffer has no valid bit of its own: it is
    // full exactly when the FSM sits in WAIT_SLOT.
    always_ff @(posedge Clk_i) begin
        if (Clr_i) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            ifPc_q     <= '0;
            ifInst_q   <= '0;
            ifValid_q  <= 1'b0;
            skidPc_q   <= '0;
            skidInst_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            ifPc_q     <= ifPc_d;
            ifInst_q   <= ifInst_d;
            ifValid_q  <= ifValid_d;
            skidPc_q   <= skidPc_d;
            skidInst_q <= skidInst_d;
        end
    end

    // Next-state logic. A redirect takes priority over normal flow; a request
    // already on the bus cannot be withdrawn, so a redirect without an ack in
    // REQ parks in DRAIN until the memory answers.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        ifPc_d     = ifPc_q;
        ifInst_d   = ifInst_q;
        ifValid_d  = ifValid_q && Stall_i;
        skidPc_d   = skidPc_q;
        skidInst_d = skidInst_q;

        if (Redirect_i) begin
            pc_d      = redirectTarget;
            ifValid_d = 1'b0;
            if ((state_q == REQ || state_q == DRAIN) && !ImemAck_i) begin
                state_d = DRAIN;
            end else begin
                addr_d  = redirectTarget;
                state_d = REQ;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    addr_d  = pc_q;
                    state_d = REQ;
                end
                REQ: begin
                    if (ImemAck_i) begin
                        pc_d = pc_q + PC_STEP;
                        if (canAccept) begin
                            ifInst_d  = ImemRdata_i;
                            ifPc_d    = addr_q;
                            ifValid_d = 1'b1;
                            addr_d    = pc_q + PC_STEP;
                        end else begin
                            skidInst_d = ImemRdata_i;
                            skidPc_d   = addr_q;
                            state_d    = WAIT_SLOT;
                        end
                    end
                end
                WAIT_SLOT: begin
                    if (!Stall_i) begin
                        ifInst_d  = skidInst_q;
                        ifPc_d    = skidPc_q;
                        ifValid_d = 1'b1;
                        addr_d    = pc_q;
                        state_d   = REQ;
                    end
                end
                DRAIN: begin
                    if (ImemAck_i) begin
                        addr_d  = pc_q;
                        state_d = REQ;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign ImemReq_o  = (state_q == REQ) || (state_q == DRAIN);
    assign ImemAddr_o = addr_q;
    assign IfPC_o     = ifPc_q;
    assign IfInst_o   = ifInst_q;
    assign IfValid_o  = ifValid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Self-checking bench for if_fetch_unit. Two instances share the inputs: one
// with RESET_PC = 0 (directed table and random run) and one with
// RESET_PC = 32'hFFFF_FFF8 (address wrap sequence). Memory data is the fetch
// address XOR a key so every returned word identifies its address.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] KEY     = 32'hA5A5_A5A5;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        Clk;
    logic        clr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        ack;

    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] ifPc0, ifPc1;
    logic [31:0] ifInst0, ifInst1;
    logic        ifValid0, ifValid1;

    int checkCount = 0;
    int failCount  = 0;

    assign rdata0 = addr0 ^ KEY;
    assign rdata1 = addr1 ^ KEY;

    if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut0 (
        .Clk_i(Clk), .Clr_i(clr), .Stall_i(stall), .Redirect_i(redirect),
        .RedirectPC_i(redirectPc), .ImemReq_o(req0), .ImemAddr_o(addr0),
        .ImemAck_i(ack), .ImemRdata_i(rdata0), .IfPC_o(ifPc0),
        .IfInst_o(ifInst0), .IfValid_o(ifValid0)
    );

    if_fetch_unit #(.XLEN(32), .RESET_PC(WRAP_PC)) dut1 (
        .Clk_i(Clk), .Clr_i(clr), .Stall_i(stall), .Redirect_i(redirect),
        .RedirectPC_i(redirectPc), .ImemReq_o(req1), .ImemAddr_o(addr1),
        .ImemAck_i(ack), .ImemRdata_i(rdata1), .IfPC_o(ifPc1),
        .IfInst_o(ifInst1), .IfValid_o(ifValid1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        clr;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic        expReq;
        logic [31:0] expAddr;
        logic [31:0] expIfPc;
        logic [31:0] expIfInst;
        logic        expValid;
    } vec_t;

    vec_t vecs [28];

    // Reference model state: a fetch stream with a pending-entry queue
    // rather than an explicit state machine.
    logic        mStarted;
    logic        mKilled;
    logic [31:0] mPc;
    logic [31:0] mAddr;
    logic        mIfValid;
    logic [31:0] mIfPc;
    logic [31:0] mIfInst;
    logic [63:0] mSkid [$];

    // Drive one cycle of inputs, let the edge happen, then settle.
    task automatic applyStimulus(input logic c, input logic s, input logic r,
                                 input logic [31:0] rpc, input logic a);
        clr        = c;
        stall      = s;
        redirect   = r;
        redirectPc = rpc;
        ack        = a;
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mStarted = 1'b0;
        mKilled  = 1'b0;
        mPc      = 32'h0;
        mAddr    = 32'h0;
        mIfValid = 1'b0;
        mIfPc    = 32'h0;
        mIfInst  = 32'h0;
        mSkid.delete();
    endtask

    // Advance the model by one clock edge using the pre-edge view.
    task automatic modelStep(input logic c, input logic s, input logic r,
                             input logic [31:0] rpc, input logic a);
        logic [31:0] tgt;
        logic        busy;
        logic        keepValid;
        logic [63:0] entry;
        tgt       = {rpc[31:2], 2'b00};
        busy      = mStarted && (mSkid.size() == 0);
        keepValid = mIfValid && s;
        if (c) begin
            modelReset();
        end else if (!mStarted) begin
            mStarted = 1'b1;
            mIfValid = 1'b0;
            if (r) begin
                mPc   = tgt;
                mAddr = tgt;
            end
        end else if (r) begin
            mPc      = tgt;
            mIfValid = 1'b0;
            mSkid.delete();
            if (busy && !a) begin
                mKilled = 1'b1;
            end else begin
                mKilled = 1'b0;
                mAddr   = tgt;
            end
        end else if (mSkid.size() != 0) begin
            if (!s) begin
                entry    = mSkid.pop_front();
                mIfPc    = entry[63:32];
                mIfInst  = entry[31:0];
                mIfValid = 1'b1;
                mAddr    = mPc;
            end
        end else if (a) begin
            if (mKilled) begin
                mKilled  = 1'b0;
                mAddr    = mPc;
                mIfValid = keepValid;
            end else if (!mIfValid || !s) begin
                mIfPc    = mAddr;
                mIfInst  = mAddr ^ KEY;
                mIfValid = 1'b1;
                mPc      = mPc + 32'd4;
                mAddr    = mPc;
            end else begin
                mSkid.push_back({mAddr, mAddr ^ KEY});
                mPc = mPc + 32'd4;
            end
        end else begin
            mIfValid = keepValid;
        end
    endtask

    initial begin
        logic        rc, rs, rr, ra;
        logic [31:0] rp;
        logic        mReq;

        clr        = 1'b1;
        stall      = 1'b0;
        redirect   = 1'b0;
        redirectPc = 32'h0;
        ack        = 1'b0;

        //            clr   stall redir rpc           ack   req   addr          ifpc          inst                  valid
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        32'h0,                1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        32'h0,                1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h0,        32'h0,                1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'h0,        32'h0 ^ KEY,          1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        32'h4,        32'h4 ^ KEY,          1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        32'h8,        32'h8 ^ KEY,          1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hC,        32'h8,        32'h8 ^ KEY,          1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hC,        32'h8,        32'h8 ^ KEY,          1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hC,        32'h8,        32'h8 ^ KEY,          1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10,       32'hC,        32'hC ^ KEY,          1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h14,       32'h10,       32'h10 ^ KEY,         1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'h0,                1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h0,        32'h0,                1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'h0,        32'h0 ^ KEY,          1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h4,        32'h0,        32'h0 ^ KEY,          1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h103,      1'b0, 1'b1, 32'h4,        32'h0,        32'h0 ^ KEY,          1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h4,        32'h0,        32'h0 ^ KEY,          1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100,      32'h0,        32'h0 ^ KEY,          1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h100,      32'h0,        32'h0 ^ KEY,          1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      32'h100,      32'h100 ^ KEY,        1'b1};
        vecs[20] = '{1'b0, 1'b1, 1'b1, 32'h200,      1'b1, 1'b1, 32'h200,      32'h100,      32'h100 ^ KEY,        1'b0};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h200,      32'h100,      32'h100 ^ KEY,        1'b0};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h204,      32'h200,      32'h200 ^ KEY,        1'b1};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h204,      32'h200,      32'h200 ^ KEY,        1'b0};
        vecs[24] = '{1'b0, 1'b0, 1'b1, 32'h300,      1'b0, 1'b1, 32'h204,      32'h200,      32'h200 ^ KEY,        1'b0};
        vecs[25] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        32'h0,                1'b0};
        vecs[26] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h0,        32'h0,                1'b0};
        vecs[27] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'h0,        32'h0 ^ KEY,          1'b1};

        @(negedge Clk);

        // Directed table: reset, streaming, stall/skid, redirects, reset in DRAIN.
        for (int i = 0; i < 28; i++) begin
            applyStimulus(vecs[i].clr, vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ack);
            checkOutput($sformatf("vec%0d.req", i),   {31'b0, req0},     {31'b0, vecs[i].expReq});
            checkOutput($sformatf("vec%0d.addr", i),  addr0,             vecs[i].expAddr);
            checkOutput($sformatf("vec%0d.ifpc", i),  ifPc0,             vecs[i].expIfPc);
            checkOutput($sformatf("vec%0d.inst", i),  ifInst0,           vecs[i].expIfInst);
            checkOutput($sformatf("vec%0d.valid", i), {31'b0, ifValid0}, {31'b0, vecs[i].expValid});
        end

        // Address wrap on the second instance.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap.resetAddr", addr1, WRAP_PC);
        checkOutput("wrap.resetValid", {31'b0, ifValid1}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap.req", {31'b0, req1}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap.pc0", ifPc1, 32'hFFFF_FFF8);
        checkOutput("wrap.inst0", ifInst1, 32'hFFFF_FFF8 ^ KEY);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap.pc1", ifPc1, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap.pc2", ifPc1, 32'h0000_0000);
        checkOutput("wrap.addr2", addr1, 32'h0000_0004);

        // Randomized run against the reference model.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        modelReset();
        for (int i = 0; i < 3000; i++) begin
            rc = ($urandom_range(63) == 0);
            rs = ($urandom_range(2) == 0);
            rr = ($urandom_range(7) == 0);
            rp = $urandom;
            ra = $urandom_range(1) == 1;
            modelStep(rc, rs, rr, rp, ra);
            applyStimulus(rc, rs, rr, rp, ra);
            mReq = mStarted && (mSkid.size() == 0);
            checkOutput($sformatf("rnd%0d.req", i),   {31'b0, req0},     {31'b0, mReq});
            checkOutput($sformatf("rnd%0d.addr", i),  addr0,             mAddr);
            checkOutput($sformatf("rnd%0d.valid", i), {31'b0, ifValid0}, {31'b0, mIfValid});
            checkOutput($sformatf("rnd%0d.ifpc", i),  ifPc0,             mIfPc);
            checkOutput($sformatf("rnd%0d.inst", i),  ifInst0,           mIfInst);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
